// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI transmit master with mode 0/2 timing and a Start/Busy/Done handshake.
// Defining SPI_TX_MASTER_MISO_EN adds MISO capture into RxData.
module spi_tx_master #(
    parameter int BITS = 32,
    parameter int DIV = 2,
    parameter int CPOL = 0,
    parameter int LSB_FIRST = 0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic [BITS-1:0] Data,
`ifdef SPI_TX_MASTER_MISO_EN
    input  logic MISO,
    output logic [BITS-1:0] RxData,
`endif
    output logic Busy,
    output logic Done,
    output logic SS,
    output logic SCLK,
    output logic MOSI
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW = $clog2(BITS);
    localparam logic idle_lvl = (CPOL != 0);

    state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [BITS-1:0] sr, sr_n;
    logic ph, ph_n, sclk_n, mosi_n, ss_n, busy_n, done_n, div_end, last_bit;

    assign div_end = dcnt == DW'(DIV - 1);
    assign last_bit = bcnt == BW'(BITS - 1);

    // ph=0 is the active SCLK half of a bit, ph=1 the idle half; MOSI moves on the ph 0->1 edge
    always_comb begin
        state_n = state;
        dcnt_n = div_end ? '0 : dcnt + 1'b1;
        bcnt_n = bcnt;
        ph_n = ph;
        sr_n = sr;
        sclk_n = SCLK;
        mosi_n = MOSI;
        ss_n = SS;
        busy_n = Busy;
        done_n = 1'b0;
        case (state)
            IDLE: begin
                dcnt_n = '0;
                if (Start) begin
                    state_n = SETUP;
                    bcnt_n = '0;
                    ph_n = 1'b0;
                    sr_n = Data;
                    mosi_n = LSB_FIRST != 0 ? Data[0] : Data[BITS-1];
                    ss_n = 1'b0;
                    busy_n = 1'b1;
                end
            end
            SETUP: if (div_end) begin
                state_n = SHIFT;
                sclk_n = ~idle_lvl;
            end
            SHIFT: if (div_end) begin
                ph_n = ~ph;
                sclk_n = ph && !last_bit ? ~idle_lvl : idle_lvl;
                if (!ph && !last_bit) begin
                    sr_n = LSB_FIRST != 0 ? sr >> 1 : sr << 1;
                    mosi_n = LSB_FIRST != 0 ? sr[1] : sr[BITS-2];
                end
                if (ph && last_bit) state_n = HOLD;
                if (ph && !last_bit) bcnt_n = bcnt + 1'b1;
            end
            HOLD: if (div_end) begin
                state_n = IDLE;
                ss_n = 1'b1;
                busy_n = 1'b0;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock)
        if (!Reset) begin
            state <= IDLE;
            dcnt <= '0;
            bcnt <= '0;
            ph <= 1'b0;
            sr <= '0;
            SCLK <= idle_lvl;
            MOSI <= 1'b0;
            SS <= 1'b1;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            state <= state_n;
            dcnt <= dcnt_n;
            bcnt <= bcnt_n;
            ph <= ph_n;
            sr <= sr_n;
            SCLK <= sclk_n;
            MOSI <= mosi_n;
            SS <= ss_n;
            Busy <= busy_n;
            Done <= done_n;
        end

`ifdef SPI_TX_MASTER_MISO_EN
    logic [BITS-1:0] rx_sr;
    logic lead;
    assign lead = div_end && (state == SETUP || (state == SHIFT && ph && !last_bit));

    always_ff @(posedge Clock)
        if (!Reset) begin
            rx_sr <= '0;
            RxData <= '0;
        end else begin
            if (lead) rx_sr <= LSB_FIRST != 0 ? {MISO, rx_sr[BITS-1:1]} : {rx_sr[BITS-2:0], MISO};
            if (done_n) RxData <= rx_sr;
        end
`endif
endmodule

// File: doc/spi_tx_master.md
SPI_TX_MASTER -- requirements
Module: spi_tx_master

Interface
REQ-001 Parameter BITS, default 32, word length in bits; SHALL be >= 2.
REQ-002 Parameter DIV, default 2, Clock cycles per SCLK half-period; SHALL be >= 1.
REQ-003 Parameter CPOL, default 0, SCLK idle level.
REQ-004 Parameter LSB_FIRST, default 0: 0 shifts MSB first, 1 shifts LSB first.
REQ-005 Clock  input  1  system clock; all logic on rising edge.
REQ-006 Reset  input  1  reset, synchronous, active-low.
REQ-007 Start  input  1  transfer request, level-sampled.
REQ-008 Data  input  BITS  word to transmit, sampled only on an accepted Start.
REQ-009 Busy  output  1  high while a transfer is in progress.
REQ-010 Done  output  1  one-cycle pulse at transfer end.
REQ-011 SS  output  1  slave select, active low.
REQ-012 SCLK  output  1  SPI clock, driven from a register, never gated from Clock.
REQ-013 MOSI  output  1  serial data out.

Function
REQ-014 States SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-015 In IDLE, Start=1 at rising edge N SHALL accept the request, load Data into the shift register, and enter SETUP.
- Start is accepted only in IDLE; Start while Busy=1 SHALL be ignored and not queued.
REQ-016 From cycle N+1, SS=0 and Busy=1; MOSI SHALL present the first bit (Data[BITS-1], or Data[0] if LSB_FIRST=1).
REQ-017 SETUP SHALL last DIV cycles with SCLK=CPOL.
REQ-018 SHIFT SHALL last 2*DIV*BITS cycles; each bit period is DIV cycles with SCLK=~CPOL, then DIV cycles with SCLK=CPOL.
REQ-019 MOSI SHALL change only on the SCLK return-to-CPOL edge (mode 0/2 timing), stable across each leading edge.
REQ-020 After the last bit, MOSI SHALL hold the last bit value.
REQ-021 HOLD SHALL last DIV cycles with SS=0 and SCLK=CPOL, then enter IDLE.
REQ-022 On entry to IDLE after HOLD:
- SS=1, Busy=0 and Done=1 for exactly that one cycle.
- Done SHALL occur at cycle N+1+2*DIV*(BITS+1).
REQ-023 Start=1 in the Done cycle SHALL be accepted (back-to-back transfer), giving SS high for exactly one cycle between words.
REQ-024 Bit counter and divider counter widths SHALL be $clog2-sized from BITS and DIV; no wrap SHALL occur before the state transition.
REQ-025 Data changes after acceptance SHALL NOT affect the word in flight.

Reset
REQ-026 Reset=0 at a rising edge SHALL force IDLE on the next cycle, including mid-transfer:
- SS=1, SCLK=CPOL, MOSI=0, Busy=0, Done=0.
- Counters and shift register cleared.
- No Done pulse generated for the aborted transfer.
REQ-027 Start SHALL be ignored while Reset=0.

Configuration
REQ-028 Macro SPI_TX_MASTER_MISO_EN:
- Defined: adds input MISO (1 bit) and output RxData (BITS bits, reset 0).
- MISO is sampled on each SCLK leading edge and shifted in the same bit order as MOSI.
- RxData is updated with the full received word in the Done cycle and held until the next Done.
- Undefined: neither port exists and no receive logic is built.

Verification
REQ-029 BITS=8, DIV=2, CPOL=0, Data=8'hA5, Start pulse at N -> MOSI bits 1,0,1,0,0,1,0,1; eight SCLK high pulses of 2 cycles each; Busy high 36 cycles; Done at N+37.
REQ-030 Same configuration with LSB_FIRST=1, Data=8'h01 -> MOSI 1 for the first bit, 0 for the remaining seven bits.
REQ-031 CPOL=1, DIV=1, BITS=4, Data=4'hC -> SCLK idles high, four low pulses of 1 cycle each, MOSI 1,1,0,0; Done at N+11.
REQ-032 Start held high continuously, BITS=8, DIV=2 -> words back-to-back, SS high exactly 1 cycle between words, one Done per word.
REQ-033 Reset=0 asserted during the third bit -> next cycle SS=1, SCLK=CPOL, Busy=0; no Done pulse; a new Start after reset transfers correctly.
REQ-034 SPI_TX_MASTER_MISO_EN defined, MISO looped back to MOSI, Data=8'h3C -> RxData=8'h3C in the Done cycle.
